// File: rtl/rsa_pkg.sv
// Shared RSA datapath types and helpers.
// Scheduler state encoding and MMM step count.
package rsa_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        RUN     = 3'd2,
        CAPTURE = 3'd3,
        RESP    = 3'd4
    } sched_state_t;

    // Run cycles one MMM operation needs for a given operand width.
    function automatic int mmm_steps(input int width);
        return width + 2;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin winner selection.
// First set req bit at or above rr_ptr, wrapping modulo NREQ.
module rr_picker #(
    parameter int NREQ = 2,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   rr_ptr,
    output logic [IW-1:0]   win,
    output logic            any_req
);

    // Scan NREQ positions starting at rr_ptr; first hit wins.
    always_comb begin
        int idx;
        logic found;
        win     = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_ptr) + k) % NREQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = IW'(idx);
            end
        end
        any_req = found;
    end

endmodule

// File: rtl/mmm_share_scheduler.sv
// Shares one Montgomery multiplier between NREQ requesters.
// Round-robin grant, operand mux, run sequencing, result capture.
module mmm_share_scheduler
    import rsa_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREQ  = 2
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              ena,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*WIDTH-1:0] a_in,
    input  logic [NREQ*WIDTH-1:0] b_in,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic [WIDTH-1:0]  res_o,
    output logic              mmm_rst,
    output logic              mmm_ld_a,
    output logic [WIDTH-1:0]  mmm_a,
    output logic [WIDTH-1:0]  mmm_b,
    input  logic [WIDTH-1:0]  mmm_p
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int SW = $clog2(mmm_steps(WIDTH));
    localparam logic [SW-1:0] LAST = SW'(mmm_steps(WIDTH) - 1);
    localparam logic [IW-1:0] TOP  = IW'(NREQ - 1);

    sched_state_t     state, state_n;
    logic [SW-1:0]    step, step_n;
    logic [IW-1:0]    win, win_n;
    logic [IW-1:0]    rr_ptr, ptr_n;
    logic [WIDTH-1:0] res_q, res_n;

    logic [IW-1:0]    pick;
    logic             any_req;
    logic             busy;

    rr_picker #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req     (req),
        .rr_ptr  (rr_ptr),
        .win     (pick),
        .any_req (any_req)
    );

    // State registers; reset wins over ena, ena gates every update.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            state  <= IDLE;
            step   <= '0;
            win    <= '0;
            rr_ptr <= '0;
            res_q  <= '0;
        end else if (ena) begin
            state  <= state_n;
            step   <= step_n;
            win    <= win_n;
            rr_ptr <= ptr_n;
            res_q  <= res_n;
        end
    end

    // Next-state and Moore outputs decoded from the current state.
    always_comb begin
        state_n  = state;
        step_n   = step;
        win_n    = win;
        ptr_n    = rr_ptr;
        res_n    = res_q;
        gnt      = '0;
        done     = '0;
        mmm_rst  = 1'b1;
        mmm_ld_a = 1'b0;
        busy     = 1'b0;
        case (state)
            IDLE: begin
                mmm_rst = 1'b0;
                if (any_req) begin
                    win_n   = pick;
                    state_n = LOAD;
                end
            end
            LOAD: begin
                busy      = 1'b1;
                gnt[win]  = 1'b1;
                mmm_ld_a  = 1'b1;
                step_n    = '0;
                state_n   = RUN;
            end
            RUN: begin
                busy     = 1'b1;
                gnt[win] = 1'b1;
                if (step == LAST) begin
                    state_n = CAPTURE;
                end else begin
                    step_n = step + 1'b1;
                end
            end
            CAPTURE: begin
                busy     = 1'b1;
                gnt[win] = 1'b1;
                res_n    = mmm_p;
                state_n  = RESP;
            end
            RESP: begin
                busy      = 1'b1;
                gnt[win]  = 1'b1;
                done[win] = 1'b1;
                ptr_n     = (win == TOP) ? '0 : win + 1'b1;
                state_n   = IDLE;
            end
            default: begin
                state_n = IDLE;
                mmm_rst = 1'b0;
                step_n  = '0;
                win_n   = '0;
                ptr_n   = '0;
                res_n   = '0;
            end
        endcase
    end

    // Granted requester's operands drive the shared multiplier.
    always_comb begin
        mmm_a = '0;
        mmm_b = '0;
        if (busy) begin
            mmm_a = a_in[int'(win)*WIDTH +: WIDTH];
            mmm_b = b_in[int'(win)*WIDTH +: WIDTH];
        end
    end

    assign res_o = res_q;

endmodule
